// File: rtl/l2cache_control.sv
// Sequencing FSM for the 4-way L2 cache datapath: miss handling, pmem handshake,
// and saturating hit/miss/writeback performance counters.
module l2cache_control #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 miss,
    input  logic                 dirty,
    output logic                 evict,
    output logic                 read,
    output logic                 commit,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 perf_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state;
    logic   miss_pending;
    logic   req;
    logic   hit_inc;
    logic   miss_inc;
    logic   wb_inc;

    assign req = mem_read | mem_write;

    // The fill lands in the same cycle the memory hands back the line.
    assign commit = (state == FILL) & pmem_resp;

    // A re-check after a fill is the miss response, so it is not a hit.
    always_comb begin
        hit_inc  = (state == CHECK) & req & ~miss & ~miss_pending;
        miss_inc = (state == CHECK) & req & miss;
        wb_inc   = (state == WRITEBACK) & pmem_resp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CHECK;
            miss_pending <= 1'b0;
            evict        <= 1'b0;
            read         <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    if (req && miss) begin
                        miss_pending <= 1'b1;
                        if (dirty) begin
                            state      <= WRITEBACK;
                            evict      <= 1'b1;
                            pmem_write <= 1'b1;
                        end else begin
                            state     <= FILL;
                            read      <= 1'b1;
                            pmem_read <= 1'b1;
                        end
                    end else begin
                        miss_pending <= 1'b0;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state      <= FILL;
                        evict      <= 1'b0;
                        pmem_write <= 1'b0;
                        read       <= 1'b1;
                        pmem_read  <= 1'b1;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state     <= CHECK;
                        read      <= 1'b0;
                        pmem_read <= 1'b0;
                    end
                end
                default: begin
                    state      <= CHECK;
                    evict      <= 1'b0;
                    read       <= 1'b0;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c,
                                                   input logic inc);
        return (inc && (c != '1)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (perf_clear) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            hit_count  <= bump(hit_count, hit_inc);
            miss_count <= bump(miss_count, miss_inc);
            wb_count   <= bump(wb_count, wb_inc);
        end
    end

endmodule

// File: tb/tb_l2cache_control.sv
// Directed bench for l2cache_control: a 32-bit-counter and a 2-bit-counter
// instance share the same stimulus.
module tb_l2cache_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, miss = 1'b0, dirty = 1'b0;
    logic pmem_resp = 1'b0, perf_clear = 1'b0;

    logic        evict, read, commit, pmem_read, pmem_write;
    logic [31:0] hit_count, miss_count, wb_count;
    logic        evict2, read2, commit2, pmem_read2, pmem_write2;
    logic [1:0]  hit_count2, miss_count2, wb_count2;

    int vectors = 0;
    int miscompares = 0;

    l2cache_control #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .miss(miss), .dirty(dirty), .evict(evict), .read(read), .commit(commit),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .perf_clear(perf_clear), .hit_count(hit_count), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    l2cache_control #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .miss(miss), .dirty(dirty), .evict(evict2), .read(read2), .commit(commit2),
        .pmem_read(pmem_read2), .pmem_write(pmem_write2), .pmem_resp(pmem_resp),
        .perf_clear(perf_clear), .hit_count(hit_count2), .miss_count(miss_count2),
        .wb_count(wb_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected control vector is {evict, read, commit, pmem_read, pmem_write}.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, 32'({evict, read, commit, pmem_read, pmem_write}), 32'(exp));
        check({tag, "_w2"}, 32'({evict2, read2, commit2, pmem_read2, pmem_write2}), 32'(exp));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] IDLE_C  = 5'b00000;
    localparam logic [4:0] WB_C    = 5'b10001;
    localparam logic [4:0] FILL_C  = 5'b01010;
    localparam logic [4:0] COMMIT_C = 5'b01110;

    initial begin
        // Reset state
        #2;
        check_ctl("reset_ctl", IDLE_C);
        check("reset_hit", hit_count, 32'd0);
        check("reset_miss", miss_count, 32'd0);
        check("reset_wb", wb_count, 32'd0);
        cyc(); rst = 1'b0;

        // Clean read miss, fill after 5 cycles, then re-check hits
        cyc(); mem_read = 1'b1; miss = 1'b1; dirty = 1'b0; #1;
        check_ctl("clean_check", IDLE_C);
        cyc(); #1;
        check_ctl("fill_enter", FILL_C);
        check("fill_miss_cnt", miss_count, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check_ctl("fill_hold", FILL_C);
        end
        cyc(); pmem_resp = 1'b1; #1;
        check_ctl("fill_commit", COMMIT_C);
        cyc(); pmem_resp = 1'b0; miss = 1'b0; #1;
        check_ctl("recheck", IDLE_C);
        cyc(); mem_read = 1'b0; #1;
        check("recheck_hit_cnt", hit_count, 32'd0);
        check("recheck_miss_cnt", miss_count, 32'd1);

        // Dirty miss: writeback then fill
        cyc(); perf_clear = 1'b1;
        cyc(); perf_clear = 1'b0; mem_read = 1'b1; miss = 1'b1; dirty = 1'b1; #1;
        check("clear_miss_cnt", miss_count, 32'd0);
        check_ctl("dirty_check", IDLE_C);
        cyc(); #1;
        check_ctl("wb_enter", WB_C);
        check("wb_miss_cnt", miss_count, 32'd1);
        cyc(); pmem_resp = 1'b1; #1;
        check_ctl("wb_resp", WB_C);
        cyc(); pmem_resp = 1'b0; dirty = 1'b0; #1;
        check_ctl("wb_to_fill", FILL_C);
        check("wb_cnt", wb_count, 32'd1);
        cyc(); pmem_resp = 1'b1; #1;
        check_ctl("wb_fill_commit", COMMIT_C);
        cyc(); pmem_resp = 1'b0; miss = 1'b0; #1;
        check_ctl("wb_recheck", IDLE_C);
        cyc(); mem_read = 1'b0; #1;
        check("wb_hit_cnt", hit_count, 32'd0);
        check("wb_miss_cnt2", miss_count, 32'd1);
        check("wb_cnt2", wb_count, 32'd1);

        // Stray pmem_resp in CHECK is ignored
        cyc(); pmem_resp = 1'b1; #1;
        check_ctl("stray_resp", IDLE_C);
        cyc(); pmem_resp = 1'b0; #1;
        check_ctl("stray_after", IDLE_C);

        // Three back-to-back hits
        cyc(); mem_read = 1'b1; miss = 1'b0; #1;
        check_ctl("hit1", IDLE_C);
        cyc(); #1;
        check_ctl("hit2", IDLE_C);
        cyc(); #1;
        check_ctl("hit3", IDLE_C);
        cyc(); mem_read = 1'b0; #1;
        check("hits3_w32", hit_count, 32'd3);
        check("hits3_w2", 32'(hit_count2), 32'd3);

        // Two more hits: 2-bit counter saturates
        cyc(); mem_read = 1'b1; #1;
        cyc(); #1;
        cyc(); mem_read = 1'b0; #1;
        check("hits5_w32", hit_count, 32'd5);
        check("hits5_w2_sat", 32'(hit_count2), 32'd3);

        // perf_clear beats a same-cycle hit
        cyc(); mem_read = 1'b1; perf_clear = 1'b1; #1;
        cyc(); mem_read = 1'b0; perf_clear = 1'b0; #1;
        check("clr_hit_w32", hit_count, 32'd0);
        check("clr_hit_w2", 32'(hit_count2), 32'd0);
        check("clr_wb", wb_count, 32'd0);

        // Write miss with request dropped mid-fill
        cyc(); mem_write = 1'b1; miss = 1'b1; dirty = 1'b0; #1;
        cyc(); mem_write = 1'b0; miss = 1'b0; #1;
        check_ctl("drop_fill", FILL_C);
        check("drop_miss_cnt", miss_count, 32'd1);
        cyc(); #1;
        check_ctl("drop_fill_hold", FILL_C);
        cyc(); pmem_resp = 1'b1; #1;
        check_ctl("drop_commit", COMMIT_C);
        cyc(); pmem_resp = 1'b0; #1;
        check_ctl("drop_back", IDLE_C);
        cyc(); #1;
        check("drop_no_hit", hit_count, 32'd0);
        cyc(); mem_read = 1'b1; #1;
        cyc(); mem_read = 1'b0; #1;
        check("drop_next_hit", hit_count, 32'd1);

        // Reset during writeback
        cyc(); mem_read = 1'b1; miss = 1'b1; dirty = 1'b1; #1;
        cyc(); #1;
        check_ctl("rst_wb", WB_C);
        check("rst_wb_miss", miss_count, 32'd2);
        cyc(); rst = 1'b1; #1;
        check_ctl("rst_mid", IDLE_C);
        check("rst_hit", hit_count, 32'd0);
        check("rst_miss", miss_count, 32'd0);
        check("rst_wb_cnt", wb_count, 32'd0);
        cyc(); rst = 1'b0; mem_read = 1'b0; miss = 1'b0; dirty = 1'b0; #1;
        check_ctl("post_rst", IDLE_C);
        cyc(); #1;
        check_ctl("post_rst2", IDLE_C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2cache_control.md
Name: l2cache_control

Overview:
- Sequencing FSM for the 4-way, 32-set, 256-bit-line L2 cache datapath.
- Consumes the datapath's `miss`/`dirty` status and drives `evict`/`read`/`commit`.
- Owns the physical-memory read/write handshake.
- Keeps saturating hit/miss/writeback performance counters that the debug logic reads.

Parameters:
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_read  input  1  upstream read request; held until datapath mem_resp
- mem_write  input  1  upstream write request; held until datapath mem_resp
- miss  input  1  datapath: request present and no way hits
- dirty  input  1  datapath: LRU victim is valid and dirty
- evict  output  1  datapath: pmem_address uses victim tag
- read  output  1  datapath: fill mode (data_in = pmem_rdata, dirty_in = 0)
- commit  output  1  datapath: write tag/valid/data/dirty/LRU of the selected way
- pmem_read  output  1  physical memory line read request
- pmem_write  output  1  physical memory line write request
- pmem_resp  input  1  physical memory transaction complete (one cycle)
- perf_clear  input  1  synchronous clear of all counters
- hit_count  output  CNT_WIDTH  first-try hits
- miss_count  output  CNT_WIDTH  misses detected
- wb_count  output  CNT_WIDTH  dirty writebacks completed

Behaviour:
- States: CHECK (reset state), WRITEBACK, FILL.
- Reset (async, rst=1):
  - state=CHECK, miss_pending=0, all counters 0.
  - evict, read, commit, pmem_read and pmem_write all 0 while rst is high.
- Outputs are Moore except `commit`:
  - CHECK: all control outputs 0.
  - WRITEBACK: evict=1, pmem_write=1, read=0, pmem_read=0, commit=0.
  - FILL: read=1, pmem_read=1, evict=0, pmem_write=0, commit=pmem_resp (combinational, same cycle as pmem_resp).
- CHECK transitions, with req = mem_read|mem_write:
  - req & miss & dirty -> WRITEBACK; set miss_pending; miss_count++.
  - req & miss & ~dirty -> FILL; set miss_pending; miss_count++.
  - req & ~miss: the datapath returns mem_resp this cycle; stay in CHECK. If miss_pending=0, hit_count++. Clear miss_pending.
  - ~req: stay; no counter activity.
- WRITEBACK transitions:
  - Hold pmem_write and evict until pmem_resp.
  - On pmem_resp -> FILL; wb_count++.
  - Victim way stays selected because LRU is not updated during writeback.
- FILL transitions:
  - Hold pmem_read until pmem_resp.
  - On pmem_resp: commit=1 for exactly that cycle, so pmem_rdata is written into the LRU way, valid=1, dirty=0, LRU updated. Then -> CHECK.
- Latency:
  - Hit: response in the same cycle as the request in CHECK.
  - Clean miss: 1 CHECK cycle + fill latency + 1 CHECK cycle (the re-check hits).
  - Dirty miss: adds the writeback latency.
- The re-check after a fill is the miss response. It is not counted as a hit (miss_pending=1).
- A write miss completes as a fill followed by a write hit in CHECK. The datapath sets dirty=1 on that hit.
- Request deasserted while in WRITEBACK/FILL:
  - The in-flight pmem transaction is never aborted; it runs to pmem_resp and commits.
  - Return to CHECK. miss_pending clears on the next CHECK cycle with no request.
- pmem_resp in CHECK is ignored. pmem_read and pmem_write are never high together.
- Counters:
  - Saturate at all-ones; no wrap.
  - perf_clear has priority over an increment in the same cycle.
  - perf_clear does not affect the FSM.
- Reset mid-transaction returns to CHECK immediately and drops the pmem request. Physical memory must be reset in the same domain.

Test Plan:
- Reset, then mem_read to a cold set (miss=1, dirty=0) -> CHECK→FILL next cycle; pmem_read=1, evict=0. pmem_resp after 5 cycles -> commit=1 in that cycle only. Then CHECK with a hit; hit_count=0, miss_count=1.
- Dirty victim miss (miss=1, dirty=1) -> WRITEBACK with evict=1, pmem_write=1. pmem_resp -> FILL with evict=0, pmem_read=1. wb_count=1, miss_count=1.
- Three back-to-back hits (miss=0, req held 3 cycles) -> outputs stay 0, hit_count=3, state remains CHECK.
- mem_write dropped mid-FILL -> pmem_read held until pmem_resp, commit pulses, returns to CHECK. No hit counted on the following request-free cycle.
- Assert rst during WRITEBACK -> pmem_write=0 immediately, state=CHECK, all counters 0.
- CNT_WIDTH=2: 5 hits -> hit_count=3 (saturated). perf_clear in the same cycle as a hit -> hit_count=0.
